// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: maps note-on/off requests onto N_VOICES TDM NCO voices
// (retrigger on match, else lowest free voice, else steal the least-recently-used one).
module voice_allocator #(
    parameter int N_VOICES = 4,
    parameter int VOICE_W  = 2,
    parameter int DIV_W    = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                note_on_stb,
    input  logic                note_off_stb,
    input  logic [6:0]          note_num,
    input  logic [6:0]          note_vel,
    input  logic [DIV_W-1:0]    note_div,
    output logic [VOICE_W-1:0]  midi_chan_selected,
    output logic [DIV_W-1:0]    midi_chan_divider,
    output logic                midi_chan_update,
    output logic [N_VOICES-1:0] voice_active,
    output logic                steal_evt,
    output logic                req_dropped,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(N_VOICES - 1);

    state_e                state_q, state_d;
    logic [VOICE_W-1:0]    scan_idx_q, scan_idx_d;
    logic [6:0]            hold_note_q, hold_note_d;
    logic [DIV_W-1:0]      hold_div_q, hold_div_d;
    logic                  hold_off_q, hold_off_d;
    logic                  match_found_q, match_found_d;
    logic [VOICE_W-1:0]    match_idx_q, match_idx_d;
    logic                  free_found_q, free_found_d;
    logic [VOICE_W-1:0]    free_idx_q, free_idx_d;
    logic [VOICE_W-1:0]    oldest_idx_q, oldest_idx_d;
    logic [N_VOICES-1:0]   active_q, active_d;
    logic [6:0]            note_q [N_VOICES];
    logic [6:0]            note_d [N_VOICES];
    logic [VOICE_W-1:0]    rank_q [N_VOICES];
    logic [VOICE_W-1:0]    rank_d [N_VOICES];
    logic [VOICE_W-1:0]    sel_q, sel_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  update_q, update_d;
    logic                  steal_q, steal_d;
    logic                  dropped_q, dropped_d;
    logic                  any_stb;
    logic [VOICE_W-1:0]    tgt;
    logic [VOICE_W-1:0]    tgt_rank;

    assign any_stb = note_on_stb | note_off_stb;

    always_comb begin
        // NOTE: every variable gets a default here so no path can leave one unassigned and infer a latch.
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        hold_note_d   = hold_note_q;
        hold_div_d    = hold_div_q;
        hold_off_d    = hold_off_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        oldest_idx_d  = oldest_idx_q;
        active_d      = active_q;
        note_d        = note_q;
        rank_d        = rank_q;
        sel_d         = sel_q;
        div_d         = div_q;
        update_d      = 1'b0;
        steal_d       = 1'b0;
        dropped_d     = 1'b0;
        tgt           = '0;
        tgt_rank      = '0;

        unique case (state_q)
            IDLE: begin
                if (any_stb) begin
                    state_d       = SCAN;
                    scan_idx_d    = '0;
                    hold_note_d   = note_num;
                    hold_div_d    = note_div;
                    hold_off_d    = note_off_stb | (note_vel == 7'd0);
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    dropped_d     = note_on_stb & note_off_stb;
                end
            end

            SCAN: begin
                dropped_d = any_stb;
                if (!match_found_q && active_q[scan_idx_q] && note_q[scan_idx_q] == hold_note_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_idx_q;
                end
                if (!free_found_q && !active_q[scan_idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_idx_q;
                end
                if (rank_q[scan_idx_q] == LAST_VOICE) begin
                    oldest_idx_d = scan_idx_q;
                end
                scan_idx_d = scan_idx_q + 1'b1;

                // The last scan cycle already sees all voices, so the decision commits here
                // and the ISSUE cycle just presents the registered strobe.
                if (scan_idx_q == LAST_VOICE) begin
                    state_d = ISSUE;
                    if (!hold_off_q) begin
                        if (match_found_d) begin
                            tgt = match_idx_d;
                        end else if (free_found_d) begin
                            tgt = free_idx_d;
                        end else begin
                            tgt     = oldest_idx_d;
                            steal_d = 1'b1;
                        end
                        tgt_rank = rank_q[tgt];
                        for (int v = 0; v < N_VOICES; v++) begin
                            if (VOICE_W'(v) == tgt) begin
                                rank_d[v] = '0;
                            end else if (rank_q[v] < tgt_rank) begin
                                rank_d[v] = rank_q[v] + 1'b1;
                            end
                        end
                        active_d[tgt] = 1'b1;
                        note_d[tgt]   = hold_note_q;
                        sel_d         = tgt;
                        div_d         = hold_div_q;
                        update_d      = 1'b1;
                    end else if (match_found_d) begin
                        active_d[match_idx_d] = 1'b0;
                        sel_d                 = match_idx_d;
                        div_d                 = '0;
                        update_d              = 1'b1;
                    end
                end
            end

            ISSUE: begin
                dropped_d = any_stb;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            scan_idx_q    <= '0;
            hold_note_q   <= '0;
            hold_div_q    <= '0;
            hold_off_q    <= 1'b0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            oldest_idx_q  <= '0;
            active_q      <= '0;
            sel_q         <= '0;
            div_q         <= '0;
            update_q      <= 1'b0;
            steal_q       <= 1'b0;
            dropped_q     <= 1'b0;
            // NOTE: the note and rank tables are tiny register arrays, so they are reset explicitly;
            // the LRU order must restart as a valid permutation.
            for (int v = 0; v < N_VOICES; v++) begin
                note_q[v] <= '0;
                rank_q[v] <= VOICE_W'(v);
            end
        end else begin
            state_q       <= state_d;
            scan_idx_q    <= scan_idx_d;
            hold_note_q   <= hold_note_d;
            hold_div_q    <= hold_div_d;
            hold_off_q    <= hold_off_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            oldest_idx_q  <= oldest_idx_d;
            active_q      <= active_d;
            note_q        <= note_d;
            rank_q        <= rank_d;
            sel_q         <= sel_d;
            div_q         <= div_d;
            update_q      <= update_d;
            steal_q       <= steal_d;
            dropped_q     <= dropped_d;
        end
    end

    assign midi_chan_selected = sel_q;
    assign midi_chan_divider  = div_q;
    assign midi_chan_update   = update_q;
    assign voice_active       = active_q;
    assign steal_evt          = steal_q;
    assign req_dropped        = dropped_q;
    assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator: one task per scenario, inline comparisons,
// expected values worked out by hand from the allocation and LRU rules.
module tb_voice_allocator;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        note_on_stb;
    logic        note_off_stb;
    logic [6:0]  note_num;
    logic [6:0]  note_vel;
    logic [15:0] note_div;
    logic [1:0]  midi_chan_selected;
    logic [15:0] midi_chan_divider;
    logic        midi_chan_update;
    logic [3:0]  voice_active;
    logic        steal_evt;
    logic        req_dropped;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Per-request observations collected by run_req
    int          upd_cnt, upd_cyc, drop_cnt, busy_first, busy_last;
    logic [1:0]  upd_sel, sel_end;
    logic [15:0] upd_div, div_end;
    logic        upd_steal, steal_seen, busy_end;
    logic [3:0]  act_end;

    voice_allocator #(.N_VOICES(4), .VOICE_W(2), .DIV_W(16)) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .note_on_stb        (note_on_stb),
        .note_off_stb       (note_off_stb),
        .note_num           (note_num),
        .note_vel           (note_vel),
        .note_div           (note_div),
        .midi_chan_selected (midi_chan_selected),
        .midi_chan_divider  (midi_chan_divider),
        .midi_chan_update   (midi_chan_update),
        .voice_active       (voice_active),
        .steal_evt          (steal_evt),
        .req_dropped        (req_dropped),
        .busy               (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // Strobe in cycle 0, observe cycles 1..6; optionally inject a second strobe at inj_at.
    task automatic run_req(input logic on, input logic off, input logic [6:0] num,
                           input logic [6:0] vel, input logic [15:0] div,
                           input int inj_at, input logic inj_on, input logic inj_off);
        @(posedge sys_clk); #1;
        note_on_stb  = on;
        note_off_stb = off;
        note_num     = num;
        note_vel     = vel;
        note_div     = div;
        upd_cnt = 0; upd_cyc = -1; drop_cnt = 0; busy_first = -1; busy_last = -1;
        upd_sel = '0; upd_div = '0; upd_steal = 1'b0; steal_seen = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge sys_clk); #1;
            note_on_stb  = 1'b0;
            note_off_stb = 1'b0;
            if (c == inj_at) begin
                note_on_stb  = inj_on;
                note_off_stb = inj_off;
                note_num     = 7'd99;
                note_vel     = 7'd100;
                note_div     = 16'hBEEF;
            end
            @(negedge sys_clk);
            if (midi_chan_update) begin
                upd_cnt++;
                if (upd_cnt == 1) begin
                    upd_cyc   = c;
                    upd_sel   = midi_chan_selected;
                    upd_div   = midi_chan_divider;
                    upd_steal = steal_evt;
                end
            end
            steal_seen = steal_seen | steal_evt;
            if (req_dropped) drop_cnt++;
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
        end
        sel_end  = midi_chan_selected;
        div_end  = midi_chan_divider;
        act_end  = voice_active;
        busy_end = busy;
    endtask

    task automatic test_reset();
        @(posedge sys_clk); #1;
        sys_rst_n   = 1'b0;
        note_on_stb = 1'b1;
        note_num    = 7'd10;
        note_vel    = 7'd50;
        note_div    = 16'h1111;
        @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (voice_active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", voice_active); end
        checks++; if ({midi_chan_update, steal_evt, req_dropped} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {midi_chan_update, steal_evt, req_dropped}); end
        checks++; if ({midi_chan_selected, midi_chan_divider} !== 18'h0) begin errors++; $display("FAIL reset_chan: got %h expected 0", {midi_chan_selected, midi_chan_divider}); end
        @(posedge sys_clk); #1;
        note_on_stb = 1'b0;
        sys_rst_n   = 1'b1;
        @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_wins_over_strobe: busy got %b expected 0", busy); end
    endtask

    task automatic test_first_note();
        run_req(1'b1, 1'b0, 7'd60, 7'd100, 16'h1234, 0, 1'b0, 1'b0);
        checks++; if (upd_cyc !== 5) begin errors++; $display("FAIL first_update_cycle: got %0d expected 5", upd_cyc); end
        checks++; if (upd_sel !== 2'd0) begin errors++; $display("FAIL first_sel: got %0d expected 0", upd_sel); end
        checks++; if (upd_div !== 16'h1234) begin errors++; $display("FAIL first_div: got %h expected 1234", upd_div); end
        checks++; if (act_end !== 4'b0001) begin errors++; $display("FAIL first_active: got %b expected 0001", act_end); end
        checks++; if (busy_first !== 1 || busy_last !== 5 || busy_end !== 1'b0) begin errors++; $display("FAIL first_busy_window: got %0d..%0d end=%b expected 1..5 end=0", busy_first, busy_last, busy_end); end
        checks++; if (upd_cnt !== 1 || steal_seen !== 1'b0 || drop_cnt !== 0) begin errors++; $display("FAIL first_pulses: upd=%0d steal=%b drop=%0d expected 1 0 0", upd_cnt, steal_seen, drop_cnt); end
        checks++; if (sel_end !== 2'd0 || div_end !== 16'h1234) begin errors++; $display("FAIL first_hold: got sel=%0d div=%h expected 0 1234", sel_end, div_end); end
    endtask

    task automatic test_fill_and_steal();
        logic [6:0]  notes [3] = '{7'd62, 7'd64, 7'd65};
        logic [15:0] divs  [3] = '{16'h2000, 16'h3000, 16'h3300};
        for (int i = 0; i < 3; i++) begin
            run_req(1'b1, 1'b0, notes[i], 7'd90, divs[i], 0, 1'b0, 1'b0);
            checks++; if (upd_sel !== 2'(i + 1) || upd_div !== divs[i] || upd_steal !== 1'b0) begin errors++; $display("FAIL fill_%0d: got sel=%0d div=%h steal=%b expected sel=%0d div=%h steal=0", i, upd_sel, upd_div, upd_steal, i + 1, divs[i]); end
        end
        checks++; if (act_end !== 4'b1111) begin errors++; $display("FAIL fill_active: got %b expected 1111", act_end); end
        run_req(1'b1, 1'b0, 7'd67, 7'd90, 16'h4000, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd0 || upd_steal !== 1'b1 || upd_div !== 16'h4000) begin errors++; $display("FAIL steal_67: got sel=%0d steal=%b div=%h expected sel=0 steal=1 div=4000", upd_sel, upd_steal, upd_div); end
        checks++; if (act_end !== 4'b1111) begin errors++; $display("FAIL steal_active: got %b expected 1111", act_end); end
        run_req(1'b1, 1'b0, 7'd69, 7'd90, 16'h4400, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd1 || upd_steal !== 1'b1) begin errors++; $display("FAIL steal_69: got sel=%0d steal=%b expected sel=1 steal=1", upd_sel, upd_steal); end
    endtask

    // Ranks after 60,62,64: (2,1,0,3); retrigger 62 -> (2,0,1,3); retrigger 60 -> (0,1,2,3);
    // 65 on free voice 3 -> (1,2,3,0); so 67 must steal voice 2.
    task automatic test_retrigger();
        do_reset();
        run_req(1'b1, 1'b0, 7'd60, 7'd80, 16'h1234, 0, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 7'd62, 7'd80, 16'h2000, 0, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 7'd64, 7'd80, 16'h3000, 0, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 7'd62, 7'd80, 16'h2001, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd1 || upd_steal !== 1'b0 || upd_div !== 16'h2001) begin errors++; $display("FAIL retrig_62: got sel=%0d steal=%b div=%h expected sel=1 steal=0 div=2001", upd_sel, upd_steal, upd_div); end
        checks++; if (act_end !== 4'b0111) begin errors++; $display("FAIL retrig_active: got %b expected 0111", act_end); end
        run_req(1'b1, 1'b0, 7'd60, 7'd80, 16'h1235, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd0 || upd_steal !== 1'b0) begin errors++; $display("FAIL retrig_60: got sel=%0d steal=%b expected sel=0 steal=0", upd_sel, upd_steal); end
        run_req(1'b1, 1'b0, 7'd65, 7'd80, 16'h3300, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd3 || upd_steal !== 1'b0) begin errors++; $display("FAIL retrig_free_65: got sel=%0d steal=%b expected sel=3 steal=0", upd_sel, upd_steal); end
        run_req(1'b1, 1'b0, 7'd67, 7'd80, 16'h4000, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd2 || upd_steal !== 1'b1) begin errors++; $display("FAIL lru_after_retrig: got sel=%0d steal=%b expected sel=2 steal=1", upd_sel, upd_steal); end
    endtask

    // Voices now hold 60,62,67,65.
    task automatic test_note_off();
        run_req(1'b0, 1'b1, 7'd62, 7'd0, 16'h0000, 0, 1'b0, 1'b0);
        checks++; if (upd_cyc !== 5 || upd_sel !== 2'd1 || upd_div !== 16'h0000) begin errors++; $display("FAIL off_62: got cyc=%0d sel=%0d div=%h expected cyc=5 sel=1 div=0000", upd_cyc, upd_sel, upd_div); end
        checks++; if (act_end !== 4'b1101) begin errors++; $display("FAIL off_62_active: got %b expected 1101", act_end); end
        run_req(1'b0, 1'b1, 7'd70, 7'd0, 16'h0000, 0, 1'b0, 1'b0);
        checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL off_unmatched_update: got %0d strobes expected 0", upd_cnt); end
        checks++; if (busy_last !== 5 || busy_end !== 1'b0 || act_end !== 4'b1101) begin errors++; $display("FAIL off_unmatched_state: busy_last=%0d end=%b act=%b expected 5 0 1101", busy_last, busy_end, act_end); end
    endtask

    task automatic test_vel0_and_drop();
        run_req(1'b1, 1'b0, 7'd60, 7'd0, 16'h7777, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd0 || upd_div !== 16'h0000 || act_end !== 4'b1100) begin errors++; $display("FAIL vel0_off: got sel=%0d div=%h act=%b expected 0 0000 1100", upd_sel, upd_div, act_end); end
        run_req(1'b1, 1'b1, 7'd65, 7'd100, 16'h5000, 0, 1'b0, 1'b0);
        checks++; if (upd_sel !== 2'd3 || upd_div !== 16'h0000 || act_end !== 4'b0100) begin errors++; $display("FAIL both_stb_off: got sel=%0d div=%h act=%b expected 3 0000 0100", upd_sel, upd_div, act_end); end
        checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL both_stb_dropped: got %0d pulses expected 1", drop_cnt); end
        run_req(1'b1, 1'b0, 7'd72, 7'd100, 16'h0ABC, 3, 1'b1, 1'b0);
        checks++; if (drop_cnt !== 1 || upd_cnt !== 1) begin errors++; $display("FAIL busy_drop: got drop=%0d upd=%0d expected 1 1", drop_cnt, upd_cnt); end
        checks++; if (upd_sel !== 2'd0 || upd_div !== 16'h0ABC || act_end !== 4'b0101) begin errors++; $display("FAIL busy_drop_issue: got sel=%0d div=%h act=%b expected 0 0abc 0101", upd_sel, upd_div, act_end); end
    endtask

    task automatic test_reset_mid_scan();
        int upd = 0;
        @(posedge sys_clk); #1;
        note_on_stb = 1'b1; note_num = 7'd80; note_vel = 7'd100; note_div = 16'h5555;
        @(posedge sys_clk); #1;
        note_on_stb = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        checks++; if (busy !== 1'b0 || voice_active !== 4'b0000) begin errors++; $display("FAIL midscan_reset_state: busy=%b act=%b expected 0 0000", busy, voice_active); end
        checks++; if (midi_chan_divider !== 16'h0000 || midi_chan_selected !== 2'd0) begin errors++; $display("FAIL midscan_reset_chan: sel=%0d div=%h expected 0 0000", midi_chan_selected, midi_chan_divider); end
        for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            if (midi_chan_update) upd++;
        end
        checks++; if (upd !== 0) begin errors++; $display("FAIL midscan_no_update: got %0d strobes expected 0", upd); end
        run_req(1'b1, 1'b0, 7'd81, 7'd100, 16'h0081, 0, 1'b0, 1'b0);
        checks++; if (upd_cyc !== 5 || upd_sel !== 2'd0 || act_end !== 4'b0001) begin errors++; $display("FAIL after_reset_note: cyc=%0d sel=%0d act=%b expected 5 0 0001", upd_cyc, upd_sel, act_end); end
    endtask

    initial begin
        sys_rst_n    = 1'b0;
        note_on_stb  = 1'b0;
        note_off_stb = 1'b0;
        note_num     = '0;
        note_vel     = '0;
        note_div     = '0;
        test_reset();
        test_first_note();
        test_fill_and_steal();
        test_retrigger();
        test_note_off();
        test_vel0_and_drop();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
